// File: rtl/elevator_scheduler.sv
// Motion and door controller for a single car serving floors 1..NUM_FLOORS.
// Reads the latched hall/car request vectors, picks a travel direction,
// steps the car one floor per travel period, stops where a request must be
// honoured, holds the door open and pulses serve_valid so the latch can
// clear the requests it just served.
module elevator_scheduler #(
   parameter int NUM_FLOORS    = 7,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] hall_up,
   input  logic [NUM_FLOORS-1:0] hall_dn,
   input  logic [NUM_FLOORS-1:0] car_req,
   output logic [2:0]            current_floor,
   output logic [1:0]            direction,
   output logic                  moving,
   output logic                  door_open,
   output logic                  serve_valid,
   output logic [2:0]            serve_floor,
   output logic [1:0]            serve_dir
);

   localparam logic [1:0]  DIR_NONE    = 2'b00;
   localparam logic [1:0]  DIR_UP      = 2'b10;
   localparam logic [1:0]  DIR_DN      = 2'b01;
   localparam logic [2:0]  TOP_FLOOR   = 3'(NUM_FLOORS);
   localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
   localparam logic [15:0] DOOR_LAST   = 16'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MOVING = 2'd1,
      ST_ARRIVE = 2'd2,
      ST_OPEN   = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  floor_reg, floor_next;
   logic [1:0]  dir_reg, dir_next;
   logic [15:0] cnt_reg, cnt_next;
   logic        sv_reg, sv_next;
   logic [2:0]  sfloor_reg, sfloor_next;
   logic [1:0]  sdir_reg, sdir_next;

   // Request vectors with the meaningless end-floor hall bits removed
   logic [NUM_FLOORS-1:0] up_m;
   logic [NUM_FLOORS-1:0] dn_m;
   logic [NUM_FLOORS-1:0] req_all;
   logic [NUM_FLOORS-1:0] here_mask;
   logic [NUM_FLOORS-1:0] above_mask;
   logic [NUM_FLOORS-1:0] below_mask;

   // The top-floor up bit and floor-1 down bit can never be honoured
   logic unused_ends;
   assign unused_ends = hall_up[NUM_FLOORS-1] ^ hall_dn[0];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
         localparam logic [2:0] FLOOR_NUM = 3'(gi + 1);
         assign here_mask[gi]  = (FLOOR_NUM == floor_reg);
         assign above_mask[gi] = (FLOOR_NUM >  floor_reg);
         assign below_mask[gi] = (FLOOR_NUM <  floor_reg);
         if (gi == NUM_FLOORS - 1) begin : g_top
            assign up_m[gi] = 1'b0;
         end else begin : g_up
            assign up_m[gi] = hall_up[gi];
         end
         if (gi == 0) begin : g_bottom
            assign dn_m[gi] = 1'b0;
         end else begin : g_dn
            assign dn_m[gi] = hall_dn[gi];
         end
      end
   endgenerate

   assign req_all = car_req | up_m | dn_m;

   logic car_here, hup_here, hdn_here, any_here;
   logic above, below;
   logic going_up, going_dn;
   logic beyond, behind, same_hall, opp_hall;
   logic arrive_stop, reload_hit;
   logic [1:0] dir_flip;

   assign car_here  = |(car_req & here_mask);
   assign hup_here  = |(up_m    & here_mask);
   assign hdn_here  = |(dn_m    & here_mask);
   assign any_here  = car_here | hup_here | hdn_here;
   assign above     = |(req_all & above_mask);
   assign below     = |(req_all & below_mask);

   // Direction-relative views of the request picture
   assign going_up  = (dir_reg == DIR_UP);
   assign going_dn  = (dir_reg == DIR_DN);
   assign beyond    = (going_up & above)    | (going_dn & below);
   assign behind    = (going_up & below)    | (going_dn & above);
   assign same_hall = (going_up & hup_here) | (going_dn & hdn_here);
   assign opp_hall  = (going_up & hdn_here) | (going_dn & hup_here);
   assign dir_flip  = {dir_reg[0], dir_reg[1]};

   // Stop when someone here wants this car now, or the opposite hall call
   // is the last thing left in this direction.
   assign arrive_stop = car_here | same_hall | (~beyond & opp_hall);

   // A served request re-latched while the door is open extends the door
   assign reload_hit = car_here
                     | ((sdir_reg == DIR_UP) & hup_here)
                     | ((sdir_reg == DIR_DN) & hdn_here);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         floor_reg  <= 3'd1;
         dir_reg    <= DIR_NONE;
         cnt_reg    <= 16'd0;
         sv_reg     <= 1'b0;
         sfloor_reg <= 3'd1;
         sdir_reg   <= DIR_NONE;
      end else begin
         state_reg  <= state_next;
         floor_reg  <= floor_next;
         dir_reg    <= dir_next;
         cnt_reg    <= cnt_next;
         sv_reg     <= sv_next;
         sfloor_reg <= sfloor_next;
         sdir_reg   <= sdir_next;
      end
   end

   // Next-state and datapath decisions
   always_comb begin
      state_next  = state_reg;
      floor_next  = floor_reg;
      dir_next    = dir_reg;
      cnt_next    = 16'd0;
      sv_next     = 1'b0;
      sfloor_next = sfloor_reg;
      sdir_next   = sdir_reg;

      case (state_reg)
         ST_IDLE: begin
            dir_next = DIR_NONE;
            if (any_here) begin
               state_next  = ST_OPEN;
               sv_next     = 1'b1;
               sfloor_next = floor_reg;
               if (hup_here) begin
                  sdir_next = DIR_UP;
               end else if (hdn_here) begin
                  sdir_next = DIR_DN;
               end else begin
                  sdir_next = DIR_NONE;
               end
            end else if (above) begin
               dir_next   = DIR_UP;
               state_next = ST_MOVING;
            end else if (below) begin
               dir_next   = DIR_DN;
               state_next = ST_MOVING;
            end
         end

         ST_MOVING: begin
            if (cnt_reg == TRAVEL_LAST) begin
               state_next = ST_ARRIVE;
               if (going_up && (floor_reg < TOP_FLOOR)) begin
                  floor_next = floor_reg + 3'd1;
               end else if (going_dn && (floor_reg > 3'd1)) begin
                  floor_next = floor_reg - 3'd1;
               end
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end

         ST_ARRIVE: begin
            if (arrive_stop) begin
               state_next  = ST_OPEN;
               sv_next     = 1'b1;
               sfloor_next = floor_reg;
               if (same_hall) begin
                  sdir_next = dir_reg;
               end else if (~beyond & opp_hall) begin
                  sdir_next = dir_flip;
               end else begin
                  sdir_next = DIR_NONE;
               end
            end else if (beyond) begin
               state_next = ST_MOVING;
            end else begin
               state_next = ST_IDLE;
               dir_next   = DIR_NONE;
            end
         end

         ST_OPEN: begin
            if (!sv_reg && reload_hit) begin
               sv_next     = 1'b1;
               sfloor_next = floor_reg;
            end else if (cnt_reg != DOOR_LAST) begin
               cnt_next = cnt_reg + 16'd1;
            end else if (dir_reg == DIR_NONE) begin
               // Served from rest: let IDLE re-evaluate everything
               state_next = ST_IDLE;
            end else if (beyond) begin
               state_next = ST_MOVING;
            end else if (behind) begin
               dir_next   = dir_flip;
               state_next = ST_MOVING;
            end else if (opp_hall) begin
               // Turn around in place for the waiting opposite hall call
               dir_next    = dir_flip;
               sv_next     = 1'b1;
               sfloor_next = floor_reg;
               sdir_next   = dir_flip;
            end else begin
               state_next = ST_IDLE;
               dir_next   = DIR_NONE;
            end
         end

         default: begin
            state_next = ST_IDLE;
            dir_next   = DIR_NONE;
         end
      endcase
   end

   // Outputs decoded from state and registered datapath
   always_comb begin
      moving        = (state_reg == ST_MOVING);
      door_open     = (state_reg == ST_OPEN);
      current_floor = floor_reg;
      direction     = dir_reg;
      serve_valid   = sv_reg;
      serve_floor   = sfloor_reg;
      serve_dir     = sdir_reg;
   end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Motion and door controller for the 2-way, 7-floor elevator.
- Consumes the latched pending-request vectors (hall up/down per floor, car buttons) from the button latch block.
- Decides travel direction, steps the car floor by floor on a travel timer, and stops at floors that must be served.
- Sequences the door, and emits a one-cycle service pulse so the latch clears the served requests.

Parameters:
NUM_FLOORS, 7, number of floors, numbered 1..NUM_FLOORS; 2..7 legal.
TRAVEL_CYCLES, 16, clock cycles spent in MOVING per one-floor step; 1..65535.
DOOR_CYCLES, 32, clock cycles the door stays open per service; 1..65535.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
hall_up  input  NUM_FLOORS  bit i-1 = pending up-call at floor i; top-floor bit ignored.
hall_dn  input  NUM_FLOORS  bit i-1 = pending down-call at floor i; floor-1 bit ignored.
car_req  input  NUM_FLOORS  bit i-1 = pending car-button request for floor i.
current_floor  output  3  floor the car is at or last passed, 1..NUM_FLOORS.
direction  output  2  2'b10 up, 2'b01 down, 2'b00 none.
moving  output  1  high while in MOVING.
door_open  output  1  high while in OPEN.
serve_valid  output  1  one-cycle pulse: requests at serve_floor are served.
serve_floor  output  3  floor being served; valid with serve_valid.
serve_dir  output  2  hall direction served (encoding as direction); 2'b00 = car request only.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: state IDLE, current_floor=1, direction=00, moving=0, door_open=0, serve_valid=0, serve_floor=1, serve_dir=00, counters 0.
- Reset asserted mid-travel or mid-door aborts immediately. There is no floor memory; the car is treated as being at floor 1.
- Helper terms, combinational from inputs and current_floor f:
  - here = car_req[f] | hall_up[f] | hall_dn[f]
  - above = any request at floors > f
  - below = any request at floors < f
- States: IDLE, MOVING, ARRIVE, OPEN.
- IDLE (direction=00). Priority order:
  - here: go to OPEN, serve_dir = 10 if hall_up[f], else 01 if hall_dn[f], else 00.
  - else above: direction=10, go to MOVING.
  - else below: direction=01, go to MOVING.
  - else stay in IDLE.
- MOVING:
  - Counter runs 0..TRAVEL_CYCLES-1.
  - On the last cycle: current_floor steps +1 (up) or -1 (down), counter clears, next state ARRIVE.
  - Inputs are ignored while in MOVING.
- ARRIVE (exactly 1 cycle), at the new floor f:
  - stop if car_req[f], OR the hall call in the current direction is pending, OR (no requests beyond f in the current direction AND the opposite hall call is pending). Stop goes to OPEN.
  - else if requests exist beyond f in the current direction: back to MOVING.
  - else (request vanished): go to IDLE, direction=00.
  - f=NUM_FLOORS while going up, or f=1 while going down: the car always stops or goes to IDLE. It never steps past the end floor.
- OPEN:
  - door_open=1 for DOOR_CYCLES cycles.
  - serve_valid pulses in the first OPEN cycle with serve_floor=f and serve_dir = the hall direction being honoured (per the ARRIVE rule, or the IDLE rule above).
  - If car_req[f], or the served-direction hall bit at f, is re-asserted after the pulse: counter reloads to 0 and serve_valid pulses again next cycle.
  - On expiry:
    - continue the same direction if requests are beyond f in it; go to MOVING.
    - else reverse if requests are beyond f the other way; direction flips, go to MOVING.
    - else reverse to serve an opposite-direction hall call pending at f: re-enter OPEN for one more service with the flipped serve_dir.
    - else go to IDLE.
- Simultaneous requests above and below with the car idle: up wins.
- Requests at f arriving while in MOVING are not served until the car returns.
- serve_valid is never high in two consecutive cycles except on a reload.
- door_open and moving are never both high.

Test Plan:
- Bench parameters: TRAVEL_CYCLES=4, DOOR_CYCLES=3, NUM_FLOORS=7.
- Reset, car at 1, car_req[3] set for 1 cycle at cycle 0 and held by the bench until serve:
  - moving=1 during cycles 1-4 and 6-9.
  - current_floor=2 at cycle 5, =3 at cycle 10.
  - door_open=1 during cycles 11-13.
  - serve_valid at cycle 11 with serve_floor=3, serve_dir=00.
  - IDLE at cycle 14.
- Car going up from 1 with car_req[6] and hall_dn[4] pending: passes floor 4 without stopping, stops at 6. Then it reverses down, stops at 4 with serve_dir=01.
- Idle at 4 with hall_up[6] and hall_dn[2] asserted the same cycle: direction=10 first, and floor 6 is served before floor 2.
- Door open at floor 5, car_req[5] re-pulsed at door cycle 2: door_open is extended by 3 cycles from the reload, and serve_valid pulses twice.
- Car going up at the top floor with only hall_up[7] set: the top-floor bit is ignored and the car does not move up. Reset asserted mid-MOVING: next cycle current_floor=1, all outputs at reset values.
